// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: shares one uart_ip between N_REQ byte producers,
// launching each byte through the control register and polling the busy flag.
module uart_tx_sched #(
  parameter int N_REQ         = 4,
  parameter int TX_BUSY_BIT   = 0,
  parameter int START_TIMEOUT = 64,
  parameter int DONE_TIMEOUT  = 1000000
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [9:0]         cfg,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   req_done,
  output logic               ctl_reg_we,
  output logic [18:0]        ctl_reg_wdata,
  output logic [18:0]        ctl_reg_wmask,
  output logic               st_reg_re,
  output logic [11:0]        st_reg_rmask,
  input  logic [11:0]        st_reg_rdata,
  output logic               busy,
  output logic               err_timeout,
  input  logic               err_clr
);
  localparam int PW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);
  localparam logic [11:0]      RMASK     = 12'(1) << TX_BUSY_BIT;
  localparam logic [19:0]      START_LIM = 20'(START_TIMEOUT - 1);
  localparam logic [19:0]      DONE_LIM  = 20'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, CLEAR, WAIT_RISE, WAIT_FALL, DONE} state_e;

  state_e            state_q;
  logic [PW-1:0]     ptr_q, win_q;
  logic [7:0]        byte_q;
  logic [9:0]        cfg_q;
  logic [19:0]       cnt_q;
  logic              samp_q, err_q, busy_q, we_q, re_q;
  logic [N_REQ-1:0]  ready_q, done_q;
  logic [18:0]       wdata_q, wmask_q;

  logic [N_REQ-1:0][7:0] req_bytes;
  logic [PW-1:0]     arb_idx;
  logic              arb_found;
  logic              rd_busy;
  logic [19:0]       cnt_inc;

  assign req_bytes = req_data;
  assign rd_busy   = |(st_reg_rdata & RMASK);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 20'd1;

  // First valid requester at or after ptr, wrapping past N_REQ-1.
  always_comb begin
    logic [PW:0] s;
    arb_found = 1'b0;
    arb_idx   = '0;
    s         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr_q} + (PW+1)'(k);
      if (s >= (PW+1)'(N_REQ)) s = s - (PW+1)'(N_REQ);
      if (!arb_found && req_valid[s[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = s[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      byte_q  <= '0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      samp_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ready_q <= '0;
      done_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      ready_q <= '0;
      done_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      re_q    <= 1'b0;
      cnt_q   <= '0;
      // A read issued last cycle returns now; only the WAIT states look at it.
      samp_q  <= re_q;
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: if (arb_found) begin
          win_q   <= arb_idx;
          byte_q  <= req_bytes[arb_idx];
          cfg_q   <= cfg;
          ready_q <= ONE << arb_idx;
          we_q    <= 1'b1;
          wdata_q <= {req_bytes[arb_idx], 1'b1, cfg};
          wmask_q <= '1;
          busy_q  <= 1'b1;
          state_q <= LAUNCH;
        end
        LAUNCH: begin
          ptr_q   <= (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          we_q    <= 1'b1;
          wdata_q <= {byte_q, 1'b0, cfg_q};
          wmask_q <= 19'h00400;
          state_q <= CLEAR;
        end
        CLEAR: begin
          re_q    <= 1'b1;
          state_q <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (samp_q && rd_busy) begin
            re_q    <= 1'b1;
            state_q <= WAIT_FALL;
          end else if (cnt_q >= START_LIM) begin
            err_q   <= 1'b1;
            done_q  <= ONE << win_q;
            state_q <= DONE;
          end else begin
            re_q  <= 1'b1;
            cnt_q <= cnt_inc;
          end
        end
        WAIT_FALL: begin
          if (samp_q && !rd_busy) begin
            done_q  <= ONE << win_q;
            state_q <= DONE;
          end else if (cnt_q >= DONE_LIM) begin
            err_q   <= 1'b1;
            done_q  <= ONE << win_q;
            state_q <= DONE;
          end else begin
            re_q  <= 1'b1;
            cnt_q <= cnt_inc;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign req_done      = done_q;
  assign ctl_reg_we    = we_q;
  assign ctl_reg_wdata = wdata_q;
  assign ctl_reg_wmask = wmask_q;
  assign st_reg_re     = re_q;
  assign st_reg_rmask  = re_q ? RMASK : 12'h000;
  assign busy          = busy_q;
  assign err_timeout   = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small uart status model answering the polls.
module tb_uart_tx_sched;
  logic        clk = 1'b0;
  logic        arst, err_clr;
  logic [9:0]  cfg;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready, req_done;
  logic        ctl_reg_we, st_reg_re, busy, err_timeout;
  logic [18:0] ctl_reg_wdata, ctl_reg_wmask;
  logic [11:0] st_reg_rmask;
  logic [11:0] st_reg_rdata = 12'h000;

  int pass = 0, total = 0;
  int bmode = 0;   // 0 normal, 1 never busy, 2 stuck busy
  int blen = 2;
  int bcnt = 0;

  uart_tx_sched #(.N_REQ(4), .TX_BUSY_BIT(0), .START_TIMEOUT(64), .DONE_TIMEOUT(200)) dut (
    .clk(clk), .arst(arst), .cfg(cfg), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .ctl_reg_we(ctl_reg_we),
    .ctl_reg_wdata(ctl_reg_wdata), .ctl_reg_wmask(ctl_reg_wmask), .st_reg_re(st_reg_re),
    .st_reg_rmask(st_reg_rmask), .st_reg_rdata(st_reg_rdata), .busy(busy),
    .err_timeout(err_timeout), .err_clr(err_clr));

  always #5 clk = ~clk;

  // Transmitter model: busy for blen cycles after a start write.
  always @(posedge clk) begin
    if (bmode == 1) bcnt <= 0;
    else if (ctl_reg_we && ctl_reg_wmask[10] && ctl_reg_wdata[10]) bcnt <= (bmode == 2) ? 32'h4000_0000 : blen;
    else if (bcnt != 0 && bmode == 0) bcnt <= bcnt - 1;
    st_reg_rdata <= st_reg_re ? {11'b0, bcnt != 0} : 12'h000;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_ready();
    int c = 0;
    while (req_ready == 4'b0 && c < 50) begin @(negedge clk); c++; end
    chk("grant seen", 32'(req_ready != 4'b0), 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (req_done == 4'b0 && n < 400);
    chk("done seen", 32'(req_done != 4'b0), 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [9:0]  cfg;
    int          blen;
    int          exp;
    int          lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n, dcount;
    logic [7:0] b;
    tbl[0] = '{4'b0100, 32'h00A5_0000, 10'h3C7, 100, 2, 103};
    tbl[1] = '{4'b0011, 32'h0000_2211, 10'h155,   2, 0,   5};
    tbl[2] = '{4'b1010, 32'h4400_3300, 10'h2AA,   5, 1,   8};
    tbl[3] = '{4'b1001, 32'h6600_0055, 10'h001,   3, 3,   6};
    tbl[4] = '{4'b1111, 32'h1312_1110, 10'h3FF,   2, 0,   5};

    arst = 1'b1; err_clr = 1'b0; cfg = '0; req_valid = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset ready/done", {req_ready, req_done}, 0);
    chk("reset we/re/busy/err", {ctl_reg_we, st_reg_re, busy, err_timeout}, 0);
    chk("reset wdata", ctl_reg_wdata, 0);
    chk("reset rmask", st_reg_rmask, 0);
    arst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      blen = tbl[i].blen;
      req_valid = tbl[i].valid; req_data = tbl[i].data; cfg = tbl[i].cfg;
      wait_ready();
      b = tbl[i].data[8*tbl[i].exp +: 8];
      chk("launch ready", req_ready, 32'(1) << tbl[i].exp);
      chk("launch we", ctl_reg_we, 1);
      chk("launch wdata", ctl_reg_wdata, {13'b0, b, 1'b1, tbl[i].cfg});
      chk("launch wmask", ctl_reg_wmask, 32'h7FFFF);
      chk("launch busy", busy, 1);
      req_valid = '0;
      @(negedge clk);
      chk("clear we", ctl_reg_we, 1);
      chk("clear wmask", ctl_reg_wmask, 32'h00400);
      chk("clear start bit", ctl_reg_wdata[10], 0);
      wait_done(n);
      chk("latency", n + 1, tbl[i].lat);
      chk("done onehot", req_done, 32'(1) << tbl[i].exp);
      chk("no timeout", err_timeout, 0);
      chk("busy in done", busy, 1);
      @(negedge clk);
      chk("busy after done", busy, 0);
    end

    // busy never rises: ptr is 1 after the table
    bmode = 1;
    req_valid = 4'b0001; req_data = 32'h0000_00C3;
    wait_ready(); req_valid = '0;
    wait_done(n);
    chk("start timeout latency", n, 66);
    chk("start timeout done", req_done, 4'b0001);
    chk("start timeout err", err_timeout, 1);
    @(negedge clk); pulse_clr();
    chk("err cleared", err_timeout, 0);
    req_valid = 4'b0010; req_data = 32'h0000_3C00;
    wait_ready(); req_valid = '0;
    repeat (65) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("coincident clr done", req_done, 4'b0010);
    chk("timeout beats clr", err_timeout, 1);
    @(negedge clk); pulse_clr();

    // busy stuck high
    bmode = 2;
    req_valid = 4'b0100; req_data = 32'h005A_0000;
    wait_ready(); req_valid = '0;
    wait_done(n);
    chk("done timeout latency", n, 204);
    chk("done timeout done", req_done, 4'b0100);
    chk("done timeout err", err_timeout, 1);
    bmode = 1; @(negedge clk); bmode = 0; pulse_clr();

    // reset during WAIT_FALL, ptr is 3 beforehand
    blen = 100;
    req_valid = 4'b0100; req_data = 32'h0077_0000;
    wait_ready(); req_valid = '0;
    repeat (10) @(negedge clk);
    arst = 1'b1; #1;
    chk("arst ready/done", {req_ready, req_done}, 0);
    chk("arst we/re/busy/err", {ctl_reg_we, st_reg_re, busy, err_timeout}, 0);
    chk("arst wdata", ctl_reg_wdata, 0);
    chk("arst wmask", ctl_reg_wmask, 0);
    chk("arst rmask", st_reg_rmask, 0);
    @(negedge clk); arst = 1'b0;
    dcount = 0;
    repeat (150) begin @(negedge clk); if (req_done != 4'b0) dcount++; end
    chk("no done after abort", dcount, 0);

    // all requesters valid: fair order from ptr 0
    blen = 2;
    req_valid = 4'b1111; req_data = 32'h1312_1110;
    for (int g = 0; g < 5; g++) begin
      wait_ready();
      chk("rr grant", req_ready, 32'(1) << (g % 4));
      chk("rr byte", ctl_reg_wdata[18:11], 32'h10 + (g % 4));
      wait_done(n);
      chk("rr done", req_done, 32'(1) << (g % 4));
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
